whack_a_mole_game: RTL and testbench

- Parametrised whack-a-mole game engine for the DE-board top level. Supports N moles (LEDs and keys) and a free-running LFSR mole picker.
- Each game round is timed and starts with an explicit start press. Misses and timeouts are counted, and mole time shrinks after each hit.
- Score is shown as a multi-digit BCD value on 7-segment displays. The game ends after a set number of misses.

---
 rtl/whack_a_mole_game.sv | 234 +++++++++++++++++++++++
 tb/tb_whack_a_mole_game.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_a_mole_game.sv
// Whack-a-mole game engine: synchronised keys, free-running LFSR mole picker,
// timed GAP/SHOW rounds, saturating BCD score on 7-segment digits, miss limit.
module whack_a_mole_game #(
    parameter int unsigned NUM_MOLES    = 4,
    parameter int unsigned TICKS_SHOW   = 50_000_000,
    parameter int unsigned TICKS_MIN    = 10_000_000,
    parameter int unsigned TICKS_STEP   = 2_000_000,
    parameter int unsigned TICKS_GAP    = 12_500_000,
    parameter int unsigned SCORE_DIGITS = 2,
    parameter int unsigned MAX_MISSES   = 3
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [NUM_MOLES-1:0]      KEY,
    input  logic                      START_N,
    output logic [NUM_MOLES-1:0]      LEDR,
    output logic [7*SCORE_DIGITS-1:0] HEX,
    output logic [3:0]                MISSES,
    output logic                      GAME_OVER
);
    localparam int unsigned MW   = $clog2(NUM_MOLES);
    localparam int unsigned CW   = MW + 1;
    localparam int unsigned TMAX = (TICKS_SHOW > TICKS_GAP) ? TICKS_SHOW : TICKS_GAP;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam int unsigned PW   = TW + 1;
    localparam int unsigned SW   = 4 * SCORE_DIGITS;
    localparam int unsigned HW   = 7 * SCORE_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_SHOW, S_OVER} state_t;

    state_t               state, state_nxt;
    logic [NUM_MOLES-1:0] key_s1, key_s2, key_s3, key_press;
    logic                 start_s1, start_s2, start_s3, start_press;
    logic [7:0]           lfsr;
    logic [NUM_MOLES-1:0] led, led_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [PW-1:0]        period, period_nxt;
    logic [SW-1:0]        score, score_nxt, score_inc;
    logic [3:0]           misses, misses_nxt;
    logic                 over, over_nxt;
    logic [MW-1:0]        prev, prev_nxt, cand, pick;
    logic [CW-1:0]        cand_w;
    logic [HW-1:0]        hex_c, hex_q;
    logic                 miss_evt, carry, all9;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Two-flop synchronisers plus a registered falling-edge detector per button
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1      <= '1;
            key_s2      <= '1;
            key_s3      <= '1;
            key_press   <= '0;
            start_s1    <= 1'b1;
            start_s2    <= 1'b1;
            start_s3    <= 1'b1;
            start_press <= 1'b0;
        end else begin
            key_s1      <= KEY;
            key_s2      <= key_s1;
            key_s3      <= key_s2;
            key_press   <= key_s3 & ~key_s2;
            start_s1    <= START_N;
            start_s2    <= start_s1;
            start_s3    <= start_s2;
            start_press <= start_s3 & ~start_s2;
        end
    end

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, runs in every state
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr <= 8'h01;
        end else if (lfsr == 8'h00) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Mole pick: fold into range, then step past the previous mole
    always_comb begin
        cand_w = {1'b0, lfsr[MW-1:0]};
        if (cand_w >= CW'(NUM_MOLES)) begin
            cand_w = cand_w - CW'(NUM_MOLES);
        end
        cand = cand_w[MW-1:0];
        pick = cand;
        if (cand == prev) begin
            if (32'(cand) + 32'd1 == NUM_MOLES) pick = '0;
            else                                pick = cand + MW'(1);
        end
    end

    // BCD increment with ripple carry, saturating at all nines
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        all9      = 1'b1;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            if (score[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (all9) score_inc = score;
    end

    always_comb begin
        state_nxt  = state;
        led_nxt    = led;
        timer_nxt  = timer;
        period_nxt = period;
        score_nxt  = score;
        misses_nxt = misses;
        over_nxt   = over;
        prev_nxt   = prev;
        miss_evt   = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                led_nxt   = '0;
                timer_nxt = '0;
                if (start_press) begin
                    score_nxt  = '0;
                    misses_nxt = 4'd0;
                    over_nxt   = 1'b0;
                    period_nxt = PW'(TICKS_SHOW);
                    state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                led_nxt = '0;
                if (timer == TW'(TICKS_GAP - 1)) begin
                    timer_nxt = '0;
                    led_nxt   = NUM_MOLES'(1) << pick;
                    prev_nxt  = pick;
                    state_nxt = S_SHOW;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_SHOW: begin
                timer_nxt = timer + TW'(1);
                if (key_press != '0) begin
                    led_nxt   = '0;
                    timer_nxt = '0;
                    if (key_press == led) begin
                        score_nxt = score_inc;
                        if (32'(period) >= TICKS_MIN + TICKS_STEP) period_nxt = period - PW'(TICKS_STEP);
                        else                                       period_nxt = PW'(TICKS_MIN);
                        state_nxt = S_GAP;
                    end else begin
                        miss_evt = 1'b1;
                    end
                end else if ({1'b0, timer} == period - PW'(1)) begin
                    led_nxt   = '0;
                    timer_nxt = '0;
                    miss_evt  = 1'b1;
                end
                if (miss_evt) begin
                    misses_nxt = misses + 4'd1;
                    if (misses_nxt == 4'(MAX_MISSES)) begin
                        state_nxt = S_OVER;
                        over_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            led    <= '0;
            timer  <= '0;
            period <= PW'(TICKS_SHOW);
            score  <= '0;
            misses <= 4'd0;
            over   <= 1'b0;
            prev   <= '0;
        end else begin
            state  <= state_nxt;
            led    <= led_nxt;
            timer  <= timer_nxt;
            period <= period_nxt;
            score  <= score_nxt;
            misses <= misses_nxt;
            over   <= over_nxt;
            prev   <= prev_nxt;
        end
    end

    always_comb begin
        hex_c = '1;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            hex_c[7*i +: 7] = seg7(score[4*i +: 4]);
        end
    end

    // Display trails the score by one cycle
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) hex_q <= {SCORE_DIGITS{7'b1000000}};
        else          hex_q <= hex_c;
    end

    assign LEDR      = led;
    assign HEX       = hex_q;
    assign MISSES    = misses;
    assign GAME_OVER = over;

endmodule

// File: tb/tb_whack_a_mole_game.sv
// Bench for whack_a_mole_game: directed rounds push expected outcomes into a
// queue; a negedge monitor pops one per mole-off event and checks it.
module tb_whack_a_mole_game;
    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic [3:0]  KEY;
    logic        START_N;
    logic [3:0]  LEDR;
    logic [13:0] HEX;
    logic [3:0]  MISSES;
    logic        GAME_OVER;

    always #5 CLOCK_50 = ~CLOCK_50;

    whack_a_mole_game #(
        .NUM_MOLES(4), .TICKS_SHOW(40), .TICKS_MIN(20), .TICKS_STEP(10),
        .TICKS_GAP(8), .SCORE_DIGITS(2), .MAX_MISSES(3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY      (KEY),
        .START_N  (START_N),
        .LEDR     (LEDR),
        .HEX      (HEX),
        .MISSES   (MISSES),
        .GAME_OVER(GAME_OVER)
    );

    typedef struct {
        int len;
        int misses;
        int score;
        bit over;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks  = 0;
    int         n_err     = 0;
    bit         mon_en    = 1'b0;
    int         exp_score = 0;
    int         exp_miss  = 0;
    int         picks     = 0;
    logic [3:0] seen      = 4'h0;

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, expv, expv, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1000000;
            1: seg = 7'b1111001;
            2: seg = 7'b0100100;
            3: seg = 7'b0110000;
            4: seg = 7'b0011001;
            5: seg = 7'b0010010;
            6: seg = 7'b0000010;
            7: seg = 7'b1111000;
            8: seg = 7'b0000000;
            9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic int hex_of(input int s);
        logic [13:0] h;
        h = {seg(s / 10), seg(s % 10)};
        return int'(h);
    endfunction

    // Monitor: measures gap/show lengths and scores each round outcome
    logic [3:0] prev_led  = 4'h0;
    int         show_cnt  = 0;
    int         zero_cnt  = 0;
    int         prev_mole = -1;
    int         idx       = 0;
    bit         gap_armed = 1'b0;
    bit         pend      = 1'b0;
    exp_t       pend_exp;

    always @(negedge CLOCK_50) begin
        if (pend) begin
            check("round_misses", int'(MISSES), pend_exp.misses);
            check("round_hex", int'(HEX), hex_of(pend_exp.score));
            check("round_game_over", int'(GAME_OVER), int'(pend_exp.over));
            pend = 1'b0;
        end
        if (mon_en) begin
            if (prev_led == 4'h0 && LEDR != 4'h0) begin
                for (int i = 0; i < 4; i++) if (LEDR[i]) idx = i;
                picks++;
                check("led_onehot", $countones(LEDR), 1);
                check("mole_not_repeated", int'(idx != prev_mole), 1);
                if (gap_armed) check("gap_len", zero_cnt, 8);
                seen[idx] = 1'b1;
                prev_mole = idx;
                show_cnt  = 1;
            end else if (prev_led != 4'h0 && LEDR != 4'h0) begin
                show_cnt++;
            end else if (prev_led != 4'h0 && LEDR == 4'h0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mole_off", 1, 0);
                end else begin
                    pend_exp = exp_q.pop_front();
                    check("show_len", show_cnt, pend_exp.len);
                    pend      = 1'b1;
                    gap_armed = !pend_exp.over;
                end
                zero_cnt = 1;
            end else begin
                zero_cnt++;
            end
        end
        prev_led = LEDR;
    end

    task automatic wait_led(input bit lit);
        int n = 0;
        while (((LEDR != 4'h0) != lit) && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(lit ? "wait_mole_on" : "wait_mole_off", int'(LEDR != 4'h0), int'(lit));
    endtask

    task automatic start_game();
        int n = 0;
        @(negedge CLOCK_50);
        START_N = 1'b0;
        while (LEDR == 4'h0 && n < 200) begin
            @(negedge CLOCK_50);
            n++;
            if (n == 4) START_N = 1'b1;
        end
        START_N = 1'b1;
        check("start_to_mole_cycles", n, 12);
        check("start_hex_zero", int'(HEX), hex_of(0));
        check("start_misses_zero", int'(MISSES), 0);
        check("start_game_over_low", int'(GAME_OVER), 0);
        exp_score = 0;
        exp_miss  = 0;
    endtask

    task automatic hit_round(input int d);
        logic [3:0] m;
        wait_led(1'b1);
        m = LEDR;
        exp_score = (exp_score < 99) ? exp_score + 1 : 99;
        exp_q.push_back('{d + 4, exp_miss, exp_score, 1'b0});
        repeat (d) @(negedge CLOCK_50);
        KEY = ~m;
        wait_led(1'b0);
        KEY = 4'hF;
    endtask

    task automatic timeout_round(input int len);
        wait_led(1'b1);
        exp_miss++;
        exp_q.push_back('{len, exp_miss, exp_score, exp_miss == 3});
        wait_led(1'b0);
    endtask

    task automatic wrong_round(input int d, input bit both, input bit hold);
        logic [3:0] m, other;
        wait_led(1'b1);
        m     = LEDR;
        other = (m == 4'b0001) ? 4'b0010 : 4'b0001;
        exp_miss++;
        exp_q.push_back('{d + 4, exp_miss, exp_score, exp_miss == 3});
        repeat (d) @(negedge CLOCK_50);
        KEY = both ? ~(m | other) : ~other;
        wait_led(1'b0);
        if (!hold) KEY = 4'hF;
    endtask

    initial begin
        RESET_N = 1'b0;
        KEY     = 4'hF;
        START_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("reset_ledr", int'(LEDR), 0);
        check("reset_hex", int'(HEX), hex_of(0));
        check("reset_misses", int'(MISSES), 0);
        check("reset_game_over", int'(GAME_OVER), 0);
        RESET_N = 1'b1;
        mon_en  = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Speed-up: 40 -> 30 -> 20, floored at 20
        start_game();
        hit_round(10);
        timeout_round(30);
        hit_round(5);
        hit_round(5);
        timeout_round(20);
        hit_round(5);
        timeout_round(20);
        repeat (3) @(negedge CLOCK_50);

        // Keys ignored once the game is over
        for (int i = 0; i < 4; i++) begin
            KEY[i] = 1'b0;
            repeat (4) @(negedge CLOCK_50);
            KEY = 4'hF;
            repeat (2) @(negedge CLOCK_50);
        end
        repeat (10) @(negedge CLOCK_50);
        check("over_ledr_dark", int'(LEDR), 0);
        check("over_flag", int'(GAME_OVER), 1);
        check("over_misses_frozen", int'(MISSES), 3);
        check("over_hex_frozen", int'(HEX), hex_of(4));

        // Three untouched rounds at full show time
        start_game();
        timeout_round(40);
        timeout_round(40);
        timeout_round(40);

        // Wrong key, double key held down, then a held key must not retrigger
        start_game();
        wrong_round(3, 1'b0, 1'b0);
        wrong_round(3, 1'b1, 1'b1);
        timeout_round(40);
        KEY = 4'hF;

        // Long run of hits drives the score into saturation
        start_game();
        repeat (190) hit_round(2);
        repeat (3) @(negedge CLOCK_50);
        check("saturated_hex", int'(HEX), hex_of(99));
        timeout_round(20);
        timeout_round(20);
        timeout_round(20);

        // Reset in the middle of a lit mole
        start_game();
        repeat (3) @(negedge CLOCK_50);
        mon_en = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_ledr", int'(LEDR), 0);
        check("async_reset_hex", int'(HEX), hex_of(0));
        check("async_reset_game_over", int'(GAME_OVER), 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        check("all_moles_seen", int'(seen), 15);
        check("enough_picks", int'(picks >= 200), 1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
